// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned RESP_LATENCY = 1;
  localparam int unsigned PKG_ADDR_W   = 32;
  localparam int unsigned PKG_DATA_W   = 32;

  typedef enum logic [1:0] {
    OWN_M0   = 2'd0,
    OWN_M1   = 2'd1,
    OWN_NONE = 2'd2
  } owner_e;

  typedef enum logic {
    RESP_IDLE,
    RESP_ACTIVE
  } resp_state_e;

  typedef struct packed {
    logic                  we;
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic [3:0]            be;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick: lock owner first, then single requester,
// then round-robin (or fixed priority to port 0) on contention.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic   req0,
  input  logic   req1,
  input  owner_e lock_owner,
  input  owner_e last_grant,
  output logic   gnt0,
  output logic   gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_owner == OWN_M0 && req0) begin
      gnt0 = 1'b1;
    end else if (lock_owner == OWN_M1 && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (ROUND_ROBIN && last_grant == OWN_M0) gnt1 = 1'b1;
      else                                     gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// debug/loader port (port 1); each grant gets a response one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  resp_state_e       state_q, state_d;
  owner_e            last_grant_q, last_grant_d;
  owner_e            lock_owner_q, lock_owner_d;
  owner_e            resp_owner_q, winner;
  logic              resp_we_q;
  logic [DATA_W-1:0] m0_hold_q, m1_hold_q, resp_rdata;
  mem_req_t          req0, req1, sel;

  rr_arbiter2 #(
    .ROUND_ROBIN(ROUND_ROBIN != 0)
  ) u_pick (
    .req0      (m0_req),
    .req1      (m1_req),
    .lock_owner(lock_owner_q),
    .last_grant(last_grant_q),
    .gnt0      (m0_gnt),
    .gnt1      (m1_gnt)
  );

  always_comb begin
    req0 = '{we: m0_we, addr: PKG_ADDR_W'(m0_addr), wdata: PKG_DATA_W'(m0_wdata), be: m0_be};
    req1 = '{we: m1_we, addr: PKG_ADDR_W'(m1_addr), wdata: PKG_DATA_W'(m1_wdata), be: m1_be};
    winner = OWN_NONE;
    sel    = '0;
    if (m0_gnt) begin
      winner = OWN_M0;
      sel    = req0;
    end else if (m1_gnt) begin
      winner = OWN_M1;
      sel    = req1;
    end
  end

  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = sel.we;
  assign mem_addr  = ADDR_W'(sel.addr & ~PKG_ADDR_W'(3));
  assign mem_wdata = DATA_W'(sel.wdata);
  assign mem_be    = sel.be;

  // Next-state: any grant opens a response slot in the following cycle;
  // a lock survives only while its owner keeps winning with lock set.
  always_comb begin
    state_d      = RESP_IDLE;
    last_grant_d = last_grant_q;
    lock_owner_d = OWN_NONE;
    if (winner != OWN_NONE) begin
      state_d      = RESP_ACTIVE;
      last_grant_d = winner;
      if ((winner == OWN_M0 && m0_lock) || (winner == OWN_M1 && m1_lock))
        lock_owner_d = winner;
    end
  end

  // Responses are driven straight from mem_rdata; the hold registers keep
  // the last value visible to each port between its own responses.
  always_comb begin
    resp_rdata = resp_we_q ? '0 : mem_rdata;
    m0_rvalid  = (state_q == RESP_ACTIVE) && (resp_owner_q == OWN_M0);
    m1_rvalid  = (state_q == RESP_ACTIVE) && (resp_owner_q == OWN_M1);
    m0_rdata   = m0_rvalid ? resp_rdata : m0_hold_q;
    m1_rdata   = m1_rvalid ? resp_rdata : m1_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESP_IDLE;
      last_grant_q <= OWN_M1;
      lock_owner_q <= OWN_NONE;
      resp_owner_q <= OWN_NONE;
      resp_we_q    <= 1'b0;
      m0_hold_q    <= '0;
      m1_hold_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_owner_q <= lock_owner_d;
      resp_owner_q <= winner;
      resp_we_q    <= sel.we;
      m0_hold_q    <= m0_rdata;
      m1_hold_q    <= m1_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance, exercised only by its own directed segment.
  logic        fp_m0_req = 1'b0, fp_m1_req = 1'b0;
  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_en, fp_mem_we;
  logic [3:0]  fp_mem_be;
  logic [31:0] fp_mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(fp_m0_req), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_be(4'hF), .m0_lock(1'b0), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m0_rdata(fp_m0_rdata),
    .m1_req(fp_m1_req), .m1_we(1'b0), .m1_addr(32'h4), .m1_wdata(32'h0),
    .m1_be(4'hF), .m1_lock(1'b0), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .m1_rdata(fp_m1_rdata),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_be(fp_mem_be), .mem_rdata(fp_mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] preload(input int i);
    if (i == 3) return 32'hABCDEF11;
    if (i == 4) return 32'h0;
    if (i == 5) return 32'hAEAEAEAE;
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Synchronous memory seen by the DUT.
  logic [31:0] env_mem [0:63];
  bit env_loaded = 1'b0;
  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= preload(i);
      env_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) env_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[7:2]];
      end
    end
  end

  // Reference model: winner from the arbitration rules, a pending-response
  // record, per-port hold values and a shadow copy of memory.
  int          m_last = 1;
  int          m_lock = -1;
  bit          pend_v = 1'b0;
  int          pend_p = 0;
  logic [31:0] pend_d = '0;
  logic [31:0] hold [2];
  logic [31:0] ref_mem [0:63];
  bit          ref_loaded = 1'b0;

  function automatic int pick();
    if (m_lock == 0 && m0_req) return 0;
    if (m_lock == 1 && m1_req) return 1;
    if (m0_req && m1_req) return (m_last == 0) ? 1 : 0;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!ref_loaded) begin
        for (int i = 0; i < 64; i++) ref_mem[i] <= preload(i);
        ref_loaded <= 1'b1;
      end
      m_last  <= 1;
      m_lock  <= -1;
      pend_v  <= 1'b0;
      hold[0] <= '0;
      hold[1] <= '0;
    end else begin
      int w;
      logic we, lk;
      logic [31:0] a, wd;
      logic [3:0] be;
      w = pick();
      if (pend_v) hold[pend_p] <= pend_d;
      pend_v <= (w >= 0);
      pend_p <= w;
      m_lock <= -1;
      if (w >= 0) begin
        we = (w == 0) ? m0_we : m1_we;
        lk = (w == 0) ? m0_lock : m1_lock;
        a  = (w == 0) ? m0_addr : m1_addr;
        wd = (w == 0) ? m0_wdata : m1_wdata;
        be = (w == 0) ? m0_be : m1_be;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[7:2]][8*b +: 8] <= wd[8*b +: 8];
          pend_d <= '0;
        end else begin
          pend_d <= ref_mem[a[7:2]];
        end
        m_last <= w;
        if (lk) m_lock <= w;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int w;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      logic        e_we;
      w = pick();
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      if (w == 0) begin
        e_we = m0_we; e_addr = m0_addr & ~32'h3; e_wdata = m0_wdata; e_be = m0_be;
      end else if (w == 1) begin
        e_we = m1_we; e_addr = m1_addr & ~32'h3; e_wdata = m1_wdata; e_be = m1_be;
      end
      chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
      chk("mem_en", 32'(mem_en), 32'(w >= 0));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_be", 32'(mem_be), 32'(e_be));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(pend_v && pend_p == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(pend_v && pend_p == 1));
      chk("m0_rdata", m0_rdata, (pend_v && pend_p == 0) ? pend_d : hold[0]);
      chk("m1_rdata", m1_rdata, (pend_v && pend_p == 1) ? pend_d : hold[1]);
    end
  end

  task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic lock);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_lock = lock;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_lock = lock;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive0(0, 0, '0, '0, '0, 0);
    drive1(0, 0, '0, '0, '0, 0);
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst m0_rdata", m0_rdata, 32'h0);
    chk("rst m1_rdata", m1_rdata, 32'h0);
    chk("rst mem_en", 32'(mem_en), 32'h0);
    next();
    rst_n = 1'b1;

    // Single m0 load of word 3
    drive0(1, 0, 32'h0C, '0, 4'hF, 0);
    @(negedge clk);
    chk("s1 m0_gnt", 32'(m0_gnt), 32'h1);
    chk("s1 mem_addr", mem_addr, 32'h0C);
    next();
    drive0(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("s1 m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("s1 m0_rdata", m0_rdata, 32'hABCDEF11);
    chk("s1 m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("s1 m1_rdata", m1_rdata, 32'h0);
    next();

    // m1 alone, leaving last grant on m1
    drive1(1, 0, 32'h14, '0, 4'hF, 0);
    @(negedge clk);
    chk("s1b m1_gnt", 32'(m1_gnt), 32'h1);
    next();

    // Continuous contention alternates
    drive0(1, 0, 32'h0C, '0, 4'hF, 0);
    drive1(1, 0, 32'h14, '0, 4'hF, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr m0_gnt", 32'(m0_gnt), 32'(k % 2 == 0));
      chk("rr m1_gnt", 32'(m1_gnt), 32'(k % 2 == 1));
      if (k > 0) chk("rr m0_rvalid", 32'(m0_rvalid), 32'(k % 2 == 1));
      next();
    end
    drive0(0, 0, '0, '0, '0, 0);
    drive1(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("rr m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("rr m1_rdata", m1_rdata, 32'hAEAEAEAE);
    next();

    // Locked m1 burst against a waiting m0
    drive0(1, 0, 32'h0C, '0, 4'hF, 0);
    @(negedge clk);
    chk("lk pre m0_gnt", 32'(m0_gnt), 32'h1);
    next();
    drive0(1, 0, 32'h10, '0, 4'hF, 0);
    drive1(1, 1, 32'h10, 32'hF2F2F2F2, 4'hF, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lk m1_gnt", 32'(m1_gnt), 32'h1);
      chk("lk m0_gnt", 32'(m0_gnt), 32'h0);
      next();
    end
    drive1(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("lk post m0_gnt", 32'(m0_gnt), 32'h1);
    next();
    drive0(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("lk readback", m0_rdata, 32'hF2F2F2F2);
    next();

    // Partial store at a misaligned address, then read back
    drive0(1, 1, 32'h16, 32'h12345678, 4'b0011, 0);
    @(negedge clk);
    chk("be mem_be", 32'(mem_be), 32'h3);
    chk("be mem_addr", mem_addr, 32'h14);
    chk("be mem_we", 32'(mem_we), 32'h1);
    next();
    drive0(1, 0, 32'h14, '0, 4'hF, 0);
    @(negedge clk);
    chk("be store ack", 32'(m0_rvalid), 32'h1);
    chk("be store rdata", m0_rdata, 32'h0);
    next();
    drive0(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("be readback", m0_rdata, 32'hAEAE5678);
    next();

    // Reset while an m1 locked load response is pending
    drive1(1, 0, 32'h0C, '0, 4'hF, 1);
    @(negedge clk);
    chk("rs m1_gnt", 32'(m1_gnt), 32'h1);
    next();
    rst_n = 1'b0;
    drive1(0, 0, '0, '0, '0, 0);
    @(negedge clk);
    chk("rs m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rs m1_rdata", m1_rdata, 32'h0);
    next();
    rst_n = 1'b1;
    drive0(1, 0, 32'h0C, '0, 4'hF, 0);
    drive1(1, 0, 32'h0C, '0, 4'hF, 1);
    @(negedge clk);
    chk("rs first m0_gnt", 32'(m0_gnt), 32'h1);
    chk("rs first m1_gnt", 32'(m1_gnt), 32'h0);
    next();
    drive0(0, 0, '0, '0, '0, 0);
    drive1(0, 0, '0, '0, '0, 0);
    next();

    // Fixed-priority instance
    fp_m1_req = 1'b1;
    @(negedge clk);
    chk("fp solo m1_gnt", 32'(fp_m1_gnt), 32'h1);
    chk("fp solo m0_gnt", 32'(fp_m0_gnt), 32'h0);
    next();
    fp_m0_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fp m0_gnt", 32'(fp_m0_gnt), 32'h1);
      chk("fp m1_gnt", 32'(fp_m1_gnt), 32'h0);
      next();
    end
    fp_m0_req = 1'b0;
    fp_m1_req = 1'b0;
    @(negedge clk);
    chk("fp idle mem_en", 32'(fp_mem_en), 32'h0);
    next();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (`dmemory`) between two requesters.
- Port 0 is the CPU load/store port. Port 1 is the debug/program-loader port, used to preload or inspect memory while the core runs or is stalled.
- Arbitration is round-robin, with a per-port lock for multi-word bursts. Each accepted access returns a one-cycle-latency response to its owner.
- Sits between `cpu` datapath and `dmemory`; the CPU stalls on `m0_gnt` low.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width (fixed 32 for RV32I).
- ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority, port 0 wins.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  CPU access request.
- m0_we  input  1  1 = store, 0 = load.
- m0_addr  input  ADDR_W  byte address.
- m0_wdata  input  DATA_W  store data.
- m0_be  input  4  byte enables.
- m0_lock  input  1  hold grant for the next cycle.
- m0_gnt  output  1  access accepted this cycle.
- m0_rvalid  output  1  response valid, one cycle after grant.
- m0_rdata  output  DATA_W  load data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the debug/loader port.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  word-aligned memory address (addr[1:0] forced to 0).
- mem_wdata  output  DATA_W  write data.
- mem_be  output  4  byte enables.
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_en.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - last_grant = 1, so port 0 wins first contention.
  - lock_owner = NONE.
  - resp_owner = NONE.
  - m*_rvalid = 0; m*_rdata = 0.
- Grant is combinational from req, lock_owner and last_grant.
  - At most one m*_gnt high per cycle.
  - mem_en = m0_gnt | m1_gnt. mem_* is muxed from the granted port.
  - When idle, mem_* = 0.
- Arbitration order:
  1. If lock_owner ≠ NONE and that port requests, it wins.
  2. Else if exactly one port requests, it wins.
  3. Else if both request: with ROUND_ROBIN=1 the port ≠ last_grant wins; with ROUND_ROBIN=0, port 0 wins.
- State update on every grant:
  - last_grant ← winner.
  - lock_owner ← winner if winner's lock = 1, else NONE.
- A lock is released when the owner drops req or lock.
- While locked, the other port's gnt stays 0 even if it requests.
- Response FSM, states IDLE / RESP:
  - A grant in cycle N → RESP in N+1, with resp_owner = winner.
  - In cycle N+1: owner's rvalid = 1 for both loads and stores (stores act as an ack). Owner's rdata = mem_rdata for loads, 0 for stores.
  - Grants in back-to-back cycles are allowed; each response lands exactly one cycle after its own grant.
  - RESP → IDLE when there is no grant in the prior cycle.
- Non-owner rdata holds its last value; its rvalid = 0.
- Misaligned address (addr[1:0] ≠ 0): access is still performed at the word-aligned address. No fault; exception handling is the CPU's job.
- Reset mid-response: pending response is discarded, no rvalid is produced, lock is cleared.
- Requests are level-held: a requester keeps req and payload stable until it sees gnt. The arbiter does not latch ungranted requests.

Decomposition:
- New package `dmem_arb_pkg`:
  - typedef `owner_e` {OWN_M0, OWN_M1, OWN_NONE}.
  - struct `mem_req_t` {we, addr, wdata, be}.
  - constant `RESP_LATENCY` = 1.
- One natural sub-module: `rr_arbiter2`, the combinational 2-way round-robin/fixed pick with lock override. The response pipeline register stays in `dmem_arbiter`.

Test Plan:
- Reset, then m0 load addr 0x0C with mem word3 = 0xABCDEF11 → m0_gnt in cycle 0, m0_rvalid with m0_rdata = 0xABCDEF11 in cycle 1; m1 signals stay 0.
- m0 and m1 both request continuously for 4 cycles → grants alternate m0, m1, m0, m1; each rvalid goes to the matching port one cycle later.
- m1 store 0xF2F2F2F2 to 0x10 with m1_lock = 1 for 3 cycles while m0 requests → m1 gets 3 consecutive grants and m0_gnt = 0. After lock drops, m0 is granted next. A later read of 0x10 returns 0xF2F2F2F2.
- Store with be = 4'b0011, data 0x12345678, to word holding 0xAEAEAEAE → mem_be = 0011 and the word reads back 0xAEAE5678.
- ROUND_ROBIN = 0 with both requesting for 3 cycles → m0 granted all 3 cycles, m1 never granted.
- Assert rst_n low in the cycle after an m1 load grant → no m1_rvalid, lock cleared. First contention after reset goes to m0.
